// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
package mem_resp_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_RANGE    = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 64-bit word: byte enables, store shift,
// load extract and natural-alignment check.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [2:0]  lane,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  byte_en_c,
  output logic [63:0] wdata_shift_c,
  output logic [63:0] rdata_ext_c,
  output logic        misalign_c
);

  logic [7:0]  size_mask;
  logic [63:0] bit_mask;
  logic [5:0]  bit_off;

  always_comb begin
    size_mask  = 8'h01;
    misalign_c = 1'b0;
    bit_mask   = '0;
    case (size_e'(size))
      SZ_BYTE:   size_mask = 8'h01;
      SZ_HALF:   begin size_mask = 8'h03; misalign_c = lane[0];    end
      SZ_WORD:   begin size_mask = 8'h0F; misalign_c = |lane[1:0]; end
      SZ_DOUBLE: begin size_mask = 8'hFF; misalign_c = |lane;      end
      default:   size_mask = 8'h01;
    endcase
    bit_off = {lane, 3'b000};
    for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
      bit_mask[8*b +: 8] = {8{size_mask[b]}};
    end
    // Aligned accesses never spill past byte 7, so truncation is harmless.
    byte_en_c     = size_mask << lane;
    wdata_shift_c = wdata << bit_off;
    rdata_ext_c   = (rword >> bit_off) & bit_mask;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: captures a load/store, waits
// LATENCY cycles, then pulses memDone with the result or an exception.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  sizeSelect,
  input  logic [63:0] address,
  input  logic [63:0] writeData,
  output logic        memReady,
  output logic        memDone,
  output logic [63:0] readData,
  output logic [1:0]  dataMemoryExc
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned AW    = IDX_W + 3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [AW-1:0]      addr_q,  addr_d;
  logic [1:0]         size_q,  size_d;
  logic [63:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  exc_e               exc_q,   exc_d;
  logic [63:0]        rdata_q, rdata_d;

  logic [63:0]        mem_q [DEPTH_WORDS];

  logic               accept_c;
  logic               mem_we_c;
  exc_e               exc_in_c;
  logic [AW-1:0]      acc_addr_c;
  logic [1:0]         acc_size_c;
  logic [63:0]        acc_wdata_c;
  logic               acc_write_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [7:0]         byte_en_c;
  logic [63:0]        wdata_shift_c;
  logic [63:0]        rdata_ext_c;
  logic               misalign_c;

  // In IDLE the live inputs drive the datapath (needed for LATENCY=1 and the
  // exception check); afterwards the captured request does.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr_c  = address[AW-1:0];
      acc_size_c  = sizeSelect;
      acc_wdata_c = writeData;
      acc_write_c = memWrite;
    end else begin
      acc_addr_c  = addr_q;
      acc_size_c  = size_q;
      acc_wdata_c = wdata_q;
      acc_write_c = write_q;
    end
  end

  assign acc_idx_c = acc_addr_c[AW-1:3];

  mem_lane_align u_align (
    .lane          (acc_addr_c[2:0]),
    .size          (acc_size_c),
    .wdata         (acc_wdata_c),
    .rword         (mem_q[acc_idx_c]),
    .byte_en_c     (byte_en_c),
    .wdata_shift_c (wdata_shift_c),
    .rdata_ext_c   (rdata_ext_c),
    .misalign_c    (misalign_c)
  );

  assign memReady = (state_q == IDLE);
  assign memDone  = (state_q == RESP);
  assign accept_c = memReady && (memRead || memWrite);

  always_comb begin
    exc_in_c = EXC_NONE;
    if (memRead && memWrite) begin
      exc_in_c = EXC_ILLEGAL;
    end else if (misalign_c) begin
      exc_in_c = EXC_MISALIGN;
    end else if (address[63:3] >= 61'(DEPTH_WORDS)) begin
      exc_in_c = EXC_RANGE;
    end
  end

  // Next-state, capture and memory-access decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    exc_d    = exc_q;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          addr_d  = address[AW-1:0];
          size_d  = sizeSelect;
          wdata_d = writeData;
          write_d = memWrite;
          if (exc_in_c != EXC_NONE) begin
            state_d = RESP;
            exc_d   = exc_in_c;
          end else if (LATENCY == 1) begin
            state_d = RESP;
            exc_d   = EXC_NONE;
            if (acc_write_c) mem_we_c = 1'b1;
            else             rdata_d  = rdata_ext_c;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          exc_d   = EXC_NONE;
          if (acc_write_c) mem_we_c = 1'b1;
          else             rdata_d  = rdata_ext_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      exc_q   <= EXC_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is never reset; a reset edge also suppresses a pending write.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
        if (byte_en_c[b]) mem_q[acc_idx_c][8*b +: 8] <= wdata_shift_c[8*b +: 8];
      end
    end
  end

  assign readData      = rdata_q;
  assign dataMemoryExc = exc_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=512, LATENCY=2).
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  sizeSelect;
  logic [63:0] address;
  logic [63:0] writeData;
  logic        memReady;
  logic        memDone;
  logic [63:0] readData;
  logic [1:0]  dataMemoryExc;

  int n_vec  = 0;
  int n_miss = 0;

  data_mem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .sizeSelect    (sizeSelect),
    .address       (address),
    .writeData     (writeData),
    .memReady      (memReady),
    .memDone       (memDone),
    .readData      (readData),
    .dataMemoryExc (dataMemoryExc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled right after accept to prove capture.
  task automatic issue(input string tag, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic [63:0] addr,
                       input logic [63:0] wd, input int exp_lat,
                       input logic [63:0] exp_rd, input logic [1:0] exp_exc);
    int lat;
    @(negedge clk);
    check_eq({tag, "_ready"}, 64'(memReady), 64'd1);
    memRead = rd; memWrite = wr; sizeSelect = sz; address = addr; writeData = wd;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    sizeSelect = ~sz; address = ~addr; writeData = ~wd;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (memDone) begin lat = i; break; end
    end
    check_eq({tag, "_lat"},   64'(lat),           64'(exp_lat));
    check_eq({tag, "_rdata"}, readData,           exp_rd);
    check_eq({tag, "_exc"},   64'(dataMemoryExc), 64'(exp_exc));
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(memDone),       64'd0);
    check_eq({tag, "_hold"},  64'(dataMemoryExc), 64'(exp_exc));
  endtask

  initial begin
    int lat;
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    sizeSelect = 2'b00; address = '0; writeData = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(memReady),      64'd1);
    check_eq("rst_done",  64'(memDone),       64'd0);
    check_eq("rst_rdata", readData,           64'd0);
    check_eq("rst_exc",   64'(dataMemoryExc), 64'd0);

    // Basic stores/loads and byte lanes.
    issue("st_d40", 0, 1, 2'b11, 64'h40, 64'h1122334455667788, 2, 64'h0, 2'b00);
    issue("ld_d40", 1, 0, 2'b11, 64'h40, 64'h0, 2, 64'h1122334455667788, 2'b00);
    issue("st_b42", 0, 1, 2'b00, 64'h42, 64'h99887766554433AB, 2, 64'h1122334455667788, 2'b00);
    issue("ld_w40", 1, 0, 2'b10, 64'h40, 64'h0, 2, 64'h0000000055AB7788, 2'b00);
    issue("st_b43", 0, 1, 2'b00, 64'h43, 64'h00000000000000CD, 2, 64'h0000000055AB7788, 2'b00);
    issue("ld_w40b", 1, 0, 2'b10, 64'h40, 64'h0, 2, 64'h00000000CDAB7788, 2'b00);
    issue("ld_h42", 1, 0, 2'b01, 64'h42, 64'h0, 2, 64'h000000000000CDAB, 2'b00);
    issue("ld_b43", 1, 0, 2'b00, 64'h43, 64'h0, 2, 64'h00000000000000CD, 2'b00);
    issue("ld_h46", 1, 0, 2'b01, 64'h46, 64'h0, 2, 64'h0000000000001122, 2'b00);

    // Misaligned accesses: early done, no data or storage change.
    issue("mis_ldh41", 1, 0, 2'b01, 64'h41, 64'h0, 1, 64'h1122, 2'b01);
    issue("mis_sth41", 0, 1, 2'b01, 64'h41, 64'hFFFF, 1, 64'h1122, 2'b01);
    issue("mis_std44", 0, 1, 2'b11, 64'h44, 64'hFFFFFFFFFFFFFFFF, 1, 64'h1122, 2'b01);
    issue("mis_stw42", 0, 1, 2'b10, 64'h42, 64'hFFFFFFFF, 1, 64'h1122, 2'b01);
    issue("ld_d40_a", 1, 0, 2'b11, 64'h40, 64'h0, 2, 64'h11223344CDAB7788, 2'b00);

    // Range boundary and illegal / priority.
    issue("rng_ld",  1, 0, 2'b11, 64'h1000, 64'h0, 1, 64'h11223344CDAB7788, 2'b10);
    issue("rng_st",  0, 1, 2'b11, 64'h1000, 64'h5, 1, 64'h11223344CDAB7788, 2'b10);
    issue("top_st",  0, 1, 2'b11, 64'hFF8, 64'h0F1E2D3C4B5A6978, 2, 64'h11223344CDAB7788, 2'b00);
    issue("top_ld",  1, 0, 2'b11, 64'hFF8, 64'h0, 2, 64'h0F1E2D3C4B5A6978, 2'b00);
    issue("ill_d40", 1, 1, 2'b11, 64'h40, 64'h0, 1, 64'h0F1E2D3C4B5A6978, 2'b11);
    issue("ill_pri", 1, 1, 2'b01, 64'h1001, 64'h0, 1, 64'h0F1E2D3C4B5A6978, 2'b11);
    issue("mis_pri", 1, 0, 2'b01, 64'h1001, 64'h0, 1, 64'h0F1E2D3C4B5A6978, 2'b01);
    issue("ld_d40_b", 1, 0, 2'b11, 64'h40, 64'h0, 2, 64'h11223344CDAB7788, 2'b00);

    // Reset during WAIT aborts the store.
    issue("st_d08", 0, 1, 2'b11, 64'h08, 64'h0123456789ABCDEF, 2, 64'h11223344CDAB7788, 2'b00);
    @(negedge clk);
    memWrite = 1'b1; sizeSelect = 2'b00; address = 64'h08; writeData = 64'hFF;
    @(posedge clk); #1;
    memWrite = 1'b0; reset = 1'b1;
    check_eq("abort_wait_done", 64'(memDone), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", 64'(memReady), 64'd1);
    check_eq("abort_done",  64'(memDone),  64'd0);
    check_eq("abort_rdata", readData,      64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_nodone", 64'(memDone), 64'd0);
    end
    issue("ld_b08", 1, 0, 2'b00, 64'h08, 64'h0, 2, 64'h00000000000000EF, 2'b00);
    issue("ld_d08", 1, 0, 2'b11, 64'h08, 64'h0, 2, 64'h0123456789ABCDEF, 2'b00);

    // A request held while busy is ignored; the first request's data lands.
    @(negedge clk);
    memWrite = 1'b1; sizeSelect = 2'b11; address = 64'h10; writeData = 64'hAAAA5555AAAA5555;
    @(posedge clk); #1;
    writeData = 64'h1234;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (memDone) begin lat = i; break; end
      check_eq("busy_ready", 64'(memReady), 64'd0);
    end
    memWrite = 1'b0;
    check_eq("busy_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("busy_nodone", 64'(memDone), 64'd0);
    end
    issue("ld_d10", 1, 0, 2'b11, 64'h10, 64'h0, 2, 64'hAAAA5555AAAA5555, 2'b00);

    // Reset wins over a simultaneous request.
    @(negedge clk);
    reset = 1'b1; memWrite = 1'b1; sizeSelect = 2'b11; address = 64'h40; writeData = 64'h0;
    @(posedge clk); #1;
    reset = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    check_eq("rstreq_ready", 64'(memReady), 64'd1);
    check_eq("rstreq_done",  64'(memDone),  64'd0);
    @(negedge clk);
    check_eq("rstreq_nodone", 64'(memDone), 64'd0);
    issue("ld_d40_c", 1, 0, 2'b11, 64'h40, 64'h0, 2, 64'h11223344CDAB7788, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
